pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter stage directly upstream of the instruction fetcher.
- Owns the PC register and drives `fixed_pc_reg`, the word index the fetcher uses to read `i_mem`.
- Normal flow: advance one word per cycle.
- Control inputs: stall (hold), redirect from branch/jump resolution, and halt.
- Internal state machine: boot, run, halt and (optionally) fault.

Parameters:
- BIN_DIG, 32: width of `redirect_pc` and `fetch_count`.
- MEM_SIZE, 256: instruction memory depth in words; must be a power of two.
- PC_WIDTH, $clog2(MEM_SIZE): width of `fixed_pc_reg`.
- RESET_PC, 0: PC loaded on reset; must be < MEM_SIZE.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- stall, input, 1: hold the PC this cycle (downstream not ready).
- redirect_valid, input, 1: load `redirect_pc` this cycle.
- redirect_pc, input, BIN_DIG: redirect target word index.
- halt_req, input, 1: stop fetching permanently until reset.
- fixed_pc_reg, output, PC_WIDTH: current PC presented to the fetcher.
- pc_valid, output, 1: `fixed_pc_reg` is a live fetch address this cycle.
- flush, output, 1: one-cycle pulse; the instruction fetched in the previous cycle must be squashed.
- halted, output, 1: block is in HALT.
- fault, output, 1: block is in FAULT; constant 0 when the macro is absent.
- fetch_count, output, BIN_DIG: number of PCs issued (advances taken).

Behaviour:
- Reset (async, `rst_n`=0):
  - state=BOOT, `fixed_pc_reg`=RESET_PC.
  - `pc_valid`=0, `flush`=0, `halted`=0, `fault`=0, `fetch_count`=0.
- BOOT:
  - Lasts exactly one cycle after `rst_n` deasserts, then goes to RUN.
  - `pc_valid`=0; all inputs ignored.
  - First valid fetch of RESET_PC is visible in the cycle after BOOT.
- RUN:
  - `pc_valid`=1 combinationally.
  - Per-edge priority: `halt_req` > `redirect_valid` > `stall` > increment.
  - halt_req: state→HALT; PC held; `flush` not asserted.
  - redirect_valid:
    - PC ← `redirect_pc`[PC_WIDTH-1:0]; `flush`=1 for the next cycle.
    - Taken even when `stall`=1 in the same cycle.
    - `fetch_count` += 1.
  - stall: PC held, `fetch_count` held, `flush`=0.
  - Otherwise: PC ← PC+1 modulo MEM_SIZE (MEM_SIZE-1 wraps to 0); `fetch_count` += 1.
- HALT:
  - Terminal until reset.
  - `pc_valid`=0, `halted`=1; PC frozen at its last value; all inputs ignored.
- `flush` is registered: high only in the cycle immediately after a redirect edge.
  - Back-to-back redirects keep `flush` high on consecutive cycles.
- `fetch_count` wraps at 2^BIN_DIG with no saturation.
- Reset asserted mid-operation, in any state, returns immediately to the reset values above.
- Latency:
  - Control input sampled at edge N affects `fixed_pc_reg` in cycle N+1.
  - No combinational path from any input to `fixed_pc_reg`.

Optional Feature:
- Macro: PC_BOUNDS_CHECK_EN.
- When defined, a FAULT state is added:
  - A redirect with `redirect_pc` ≥ MEM_SIZE enters FAULT.
  - An increment from PC=MEM_SIZE-1 also enters FAULT.
  - In FAULT: `fault`=1, `pc_valid`=0, PC holds its pre-fault value, `fetch_count` does not advance, `flush`=0.
  - FAULT is left only by reset.
  - `halt_req` in the same cycle as a fault condition wins: state goes to HALT, not FAULT.
- When undefined:
  - No FAULT state; `fault` tied to 0.
  - Redirect targets are truncated to PC_WIDTH bits; increments wrap modulo MEM_SIZE.

Test Plan:
- Reset release, no stimulus for 4 cycles:
  - Cycle 0 (BOOT): `pc_valid`=0.
  - Then `fixed_pc_reg` = 0,1,2 with `pc_valid`=1; `fetch_count`=3 after the third advance.
- `stall`=1 for 3 cycles at PC=5 → PC stays 5, `fetch_count` frozen; release → PC=6 next cycle.
- `redirect_valid`=1 and `stall`=1 with `redirect_pc`=0x40 at PC=10 → next cycle PC=0x40 and `flush`=1; following cycle PC=0x41 and `flush`=0.
- Free-run from PC=254 (MEM_SIZE=256):
  - Without macro: sequence 254, 255, 0, `fault`=0.
  - With PC_BOUNDS_CHECK_EN: after 255 the block enters FAULT, `fault`=1, `pc_valid`=0, PC=255.
- `halt_req`=1 together with `redirect_valid`=1 at PC=7 → `halted`=1, PC=7, `flush`=0; subsequent redirects ignored.
- Assert `rst_n`=0 mid-cycle while in HALT, no clock edge → outputs immediately take reset values; release → BOOT then PC=RESET_PC valid.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage feeding the instruction fetcher.
// Optional bounds checking with a FAULT state is enabled by defining PC_BOUNDS_CHECK_EN.
module pc_sequencer #(
  parameter int BIN_DIG  = 32,
  parameter int MEM_SIZE = 256,
  parameter int PC_WIDTH = $clog2(MEM_SIZE),
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [BIN_DIG-1:0]  redirect_pc,
  input  logic                halt_req,
  output logic [PC_WIDTH-1:0] fixed_pc_reg,
  output logic                pc_valid,
  output logic                flush,
  output logic                halted,
  output logic                fault,
  output logic [BIN_DIG-1:0]  fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;
  state_t state, state_n;
  logic [PC_WIDTH-1:0] pc_n;
  logic [BIN_DIG-1:0] count_n;
  logic flush_n, oob, at_top;
`ifdef PC_BOUNDS_CHECK_EN
  assign oob = |(redirect_pc >> PC_WIDTH);
  assign at_top = &fixed_pc_reg;
`else
  logic unused_hi;
  assign unused_hi = ^redirect_pc[BIN_DIG-1:PC_WIDTH];
  assign oob = 1'b0;
  assign at_top = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      fixed_pc_reg <= PC_WIDTH'(RESET_PC);
      flush <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      fixed_pc_reg <= pc_n;
      flush <= flush_n;
      fetch_count <= count_n;
    end
  end
  // Priority within RUN: halt > redirect > stall > increment
  always_comb begin
    state_n = state;
    pc_n = fixed_pc_reg;
    flush_n = 1'b0;
    count_n = fetch_count;
    if (state == BOOT) state_n = RUN;
    else if (state == RUN) begin
      if (halt_req) state_n = HALT;
      else if (redirect_valid) begin
        if (oob) state_n = FAULT;
        else begin
          pc_n = redirect_pc[PC_WIDTH-1:0];
          flush_n = 1'b1;
          count_n = fetch_count + BIN_DIG'(1);
        end
      end else if (!stall) begin
        if (at_top) state_n = FAULT;
        else begin
          pc_n = fixed_pc_reg + PC_WIDTH'(1);
          count_n = fetch_count + BIN_DIG'(1);
        end
      end
    end
  end
  always_comb begin
    pc_valid = state == RUN;
    halted = state == HALT;
`ifdef PC_BOUNDS_CHECK_EN
    fault = state == FAULT;
`else
    fault = 1'b0;
`endif
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer.
module tb_pc_sequencer;
  logic clk, rst_n, stall, redirect_valid, halt_req;
  logic [31:0] redirect_pc, fetch_count;
  logic [7:0] fixed_pc_reg;
  logic pc_valid, flush, halted, fault;
  int checks = 0;
  int errors = 0;
  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .fixed_pc_reg(fixed_pc_reg),
    .pc_valid(pc_valid), .flush(flush), .halted(halted), .fault(fault),
    .fetch_count(fetch_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_run(input string tag, input logic [7:0] pc, input logic [31:0] cnt, input logic fl);
    check({tag, "_pc"}, 32'(fixed_pc_reg), 32'(pc));
    check({tag, "_cnt"}, fetch_count, cnt);
    check({tag, "_flush"}, 32'(flush), 32'(fl));
    check({tag, "_valid"}, 32'(pc_valid), 1);
  endtask
  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    step(); step();
    check("rst_pc", 32'(fixed_pc_reg), 0);
    check("rst_valid", 32'(pc_valid), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_cnt", fetch_count, 0);
    rst_n = 1'b1;
    #1 check("boot_valid", 32'(pc_valid), 0);
    step(); expect_run("first", 8'd0, 0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(); expect_run("adv", 8'(i), 32'(i), 1'b0);
    end
    stall = 1'b1;
    repeat (3) begin
      step(); expect_run("stall", 8'd5, 5, 1'b0);
    end
    stall = 1'b0;
    step(); expect_run("unstall", 8'd6, 6, 1'b0);
    repeat (4) step();
    expect_run("at10", 8'd10, 10, 1'b0);
    redirect_valid = 1'b1; stall = 1'b1; redirect_pc = 32'h40;
    step(); expect_run("redir", 8'h40, 11, 1'b1);
    redirect_valid = 1'b0; stall = 1'b0;
    step(); expect_run("post_redir", 8'h41, 12, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step(); expect_run("b2b_a", 8'h80, 13, 1'b1);
    redirect_pc = 32'h90;
    step(); expect_run("b2b_b", 8'h90, 14, 1'b1);
`ifdef PC_BOUNDS_CHECK_EN
    redirect_pc = 32'hFE;
`else
    redirect_pc = 32'h1FE;
`endif
    step(); expect_run("to254", 8'hFE, 15, 1'b1);
    redirect_valid = 1'b0;
    step(); expect_run("at255", 8'hFF, 16, 1'b0);
    step();
`ifdef PC_BOUNDS_CHECK_EN
    check("wrap_fault", 32'(fault), 1);
    check("wrap_valid", 32'(pc_valid), 0);
    check("wrap_pc", 32'(fixed_pc_reg), 32'hFF);
    check("wrap_cnt", fetch_count, 16);
`else
    expect_run("wrap", 8'h00, 17, 1'b0);
    check("wrap_fault", 32'(fault), 0);
`endif
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_pc", 32'(fixed_pc_reg), 0);
    check("mid_rst_cnt", fetch_count, 0);
    check("mid_rst_fault", 32'(fault), 0);
    rst_n = 1'b1;
    step(); expect_run("rerun", 8'd0, 0, 1'b0);
    repeat (7) step();
    expect_run("at7", 8'd7, 7, 1'b0);
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h30;
    step();
    check("halt_halted", 32'(halted), 1);
    check("halt_pc", 32'(fixed_pc_reg), 7);
    check("halt_flush", 32'(flush), 0);
    check("halt_valid", 32'(pc_valid), 0);
    check("halt_cnt", fetch_count, 7);
    halt_req = 1'b0;
    repeat (2) step();
    check("halt_hold_pc", 32'(fixed_pc_reg), 7);
    check("halt_hold_halted", 32'(halted), 1);
    check("halt_hold_flush", 32'(flush), 0);
    #2 rst_n = 1'b0;
    #1;
    check("halt_rst_halted", 32'(halted), 0);
    check("halt_rst_pc", 32'(fixed_pc_reg), 0);
    check("halt_rst_valid", 32'(pc_valid), 0);
    check("halt_rst_cnt", fetch_count, 0);
    #1 rst_n = 1'b1; redirect_valid = 1'b0;
    #1 check("reboot_valid", 32'(pc_valid), 0);
    step(); expect_run("reboot", 8'd0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
